// File: rtl/mat_mac_sequencer.sv
// mat_mac_sequencer: feeds operand beats to the packed DSP multiply array, tracks its
// pipeline latency and accumulates per-lane tree results into a valid/ready result.
module mat_mac_sequencer #(
  parameter int MAT_WIDTH = 4,
  parameter int ACT_W     = 24,
  parameter int WGT_W     = 18,
  parameter int TREE_W    = 32,
  parameter int ACC_W     = 32,
  parameter int MULT_LAT  = 3,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode_cfg,
  input  logic [CNT_W-1:0]           ci_tiles,
  output logic                       busy,
  output logic                       done,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [MAT_WIDTH*ACT_W-1:0] op_act,
  input  logic [WGT_W-1:0]           op_wgt,
  output logic                       mat_en,
  output logic [MAT_WIDTH*ACT_W-1:0] mat_I_A,
  output logic [WGT_W-1:0]           mat_I_B,
  output logic                       mat_mode,
  input  logic [TREE_W-1:0]          mat_O,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [2*ACC_W-1:0]         res_data
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_t;
  state_t                     state_q;
  logic                       mode_q, en_q, done_q;
  logic [CNT_W-1:0]           tiles_q, cnt_q;
  logic [MULT_LAT-1:0]        pipe_q;
  logic [ACC_W-1:0]           acc0_q, acc1_q;
  logic [2*ACC_W-1:0]         res_q;
  logic [MAT_WIDTH*ACT_W-1:0] a_q;
  logic [WGT_W-1:0]           b_q;
  logic                       accept, last_beat, qual, pipe_empty;
  logic [ACC_W-1:0]           add0, add1;
  assign accept     = (state_q == FEED) && op_valid;
  assign last_beat  = (cnt_q + CNT_W'(1)) == tiles_q;
  assign qual       = pipe_q[MULT_LAT-1];
  assign pipe_empty = !en_q && (pipe_q == '0);
  // lane 0 is 24 bits wide in 8x8 mode, 16 bits in 1x8 mode
  assign add0 = mode_q ? {{(ACC_W-16){mat_O[15]}}, mat_O[15:0]}
                       : {{(ACC_W-24){mat_O[23]}}, mat_O[23:0]};
  assign add1 = {{(ACC_W-16){mat_O[31]}}, mat_O[31:16]};
  assign busy      = state_q != IDLE;
  assign op_ready  = state_q == FEED;
  assign res_valid = state_q == OUT;
  assign done      = done_q;
  assign mat_en    = en_q;
  assign mat_I_A   = a_q;
  assign mat_I_B   = b_q;
  assign mat_mode  = mode_q;
  assign res_data  = res_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      tiles_q <= '0;
      cnt_q   <= '0;
      pipe_q  <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      en_q   <= accept;
      pipe_q <= MULT_LAT'({pipe_q, en_q});
      done_q <= 1'b0;
      if (accept) begin
        a_q   <= op_act;
        b_q   <= op_wgt;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (qual) begin
        acc0_q <= acc0_q + add0;
        if (mode_q) acc1_q <= acc1_q + add1;
      end
      case (state_q)
        IDLE: if (start) begin
          mode_q  <= mode_cfg;
          tiles_q <= ci_tiles;
          cnt_q   <= '0;
          acc0_q  <= '0;
          acc1_q  <= '0;
          state_q <= (ci_tiles != '0) ? FEED : OUT;
          if (ci_tiles == '0) res_q <= '0;
        end
        FEED: if (accept && last_beat) state_q <= DRAIN;
        DRAIN: if (pipe_empty && cnt_q == tiles_q) begin
          state_q <= OUT;
          res_q   <= {acc1_q, acc0_q};
        end
        default: if (res_ready) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mat_mac_sequencer.sv
// tb_mat_mac_sequencer: directed scenarios against a fixed-latency array model.
module tb_mat_mac_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, mode_cfg = 1'b0;
  logic [15:0] ci_tiles = '0;
  logic        busy, done, op_ready, mat_en, mat_mode, res_valid;
  logic        op_valid = 1'b0, res_ready = 1'b0;
  logic [95:0] op_act = '0, mat_I_A;
  logic [17:0] op_wgt = '0, mat_I_B;
  logic [31:0] mat_O;
  logic [63:0] res_data;
  logic [31:0] sh [3] = '{default: 32'h0};
  logic [31:0] mo_val = 32'h0, mo_tail = 32'h0;
  int mo_n = 1000000, mo_base = 0, en_cnt = 0, done_cnt = 0;
  int checks = 0, errors = 0;

  mat_mac_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mode_cfg(mode_cfg), .ci_tiles(ci_tiles),
    .busy(busy), .done(done), .op_valid(op_valid), .op_ready(op_ready), .op_act(op_act),
    .op_wgt(op_wgt), .mat_en(mat_en), .mat_I_A(mat_I_A), .mat_I_B(mat_I_B),
    .mat_mode(mat_mode), .mat_O(mat_O), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  always #5 clk = ~clk;

  // array model: result appears MULT_LAT cycles after the issue, garbage otherwise
  always @(posedge clk) begin
    sh[0] <= mat_en ? ((en_cnt - mo_base < mo_n) ? mo_val : mo_tail) : 32'hDEADBEEF;
    sh[1] <= sh[0];
    sh[2] <= sh[1];
    if (mat_en) en_cnt <= en_cnt + 1;
  end
  assign mat_O = sh[2];

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic start_job(input logic m, input logic [15:0] t);
    @(negedge clk);
    start = 1'b1; mode_cfg = m; ci_tiles = t;
    @(negedge clk);
    start = 1'b0; mode_cfg = ~m; ci_tiles = t + 16'd3;
  endtask

  task automatic finish_job(input logic [63:0] exp, input string nm);
    int n = 0;
    while (!res_valid && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL %s res_valid timeout: got %b want 1", nm, res_valid); end
    checks++;
    if (res_data !== exp) begin errors++; $display("FAIL %s res_data: got %h want %h", nm, res_data, exp); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if ({res_valid, done} !== 2'b01) begin errors++; $display("FAIL %s handshake {res_valid,done}: got %b want 01", nm, {res_valid, done}); end
    @(negedge clk);
    checks++;
    if ({done, busy, res_data} !== {2'b00, exp}) begin errors++; $display("FAIL %s after done {done,busy,res_data}: got %h want %h", nm, {done, busy, res_data}, {2'b00, exp}); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, op_ready, mat_en, mat_mode, res_valid, mat_I_A, mat_I_B, res_data} !== '0) begin
      errors++; $display("FAIL reset outputs: got busy=%b done=%b rdy=%b en=%b mode=%b rv=%b A=%h B=%h res=%h want all 0",
        busy, done, op_ready, mat_en, mat_mode, res_valid, mat_I_A, mat_I_B, res_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int e0 = en_cnt;
    mo_base = en_cnt; mo_val = 32'h10;
    op_valid = 1'b1; op_act = {4{24'hA5A5A5}}; op_wgt = 18'h2AAAA;
    start_job(1'b0, 16'd3);
    checks++;
    if ({busy, op_ready, mat_mode} !== 3'b110) begin errors++; $display("FAIL basic feed flags: got %b want 110", {busy, op_ready, mat_mode}); end
    @(negedge clk);
    checks++;
    if ({mat_en, mat_I_A, mat_I_B} !== {1'b1, {4{24'hA5A5A5}}, 18'h2AAAA}) begin
      errors++; $display("FAIL basic issue: got en=%b A=%h B=%h", mat_en, mat_I_A, mat_I_B);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL basic early res_valid: got %b want 0", res_valid); end
    @(negedge clk);
    checks++;
    if ({res_valid, op_ready} !== 2'b10) begin errors++; $display("FAIL basic latency {res_valid,op_ready}: got %b want 10", {res_valid, op_ready}); end
    op_valid = 1'b0;
    finish_job({32'h0, 32'h30}, "basic");
    checks++;
    if (en_cnt - e0 !== 3) begin errors++; $display("FAIL basic mat_en count: got %0d want 3", en_cnt - e0); end
  endtask

  task automatic test_mode1;
    mo_base = en_cnt; mo_val = 32'hFFFF0002; op_valid = 1'b1;
    start_job(1'b1, 16'd2);
    checks++;
    if (mat_mode !== 1'b1) begin errors++; $display("FAIL mode1 mat_mode: got %b want 1", mat_mode); end
    finish_job({32'hFFFFFFFE, 32'h00000004}, "mode1");
    op_valid = 1'b0;
  endtask

  task automatic test_stall;
    logic [6:0] pat = 7'b1011001;
    int e0 = en_cnt, d0 = done_cnt;
    mo_base = en_cnt; mo_val = 32'hABFFFFFF;
    start_job(1'b0, 16'd4);
    for (int i = 0; i < 7; i++) begin
      op_valid = pat[i]; op_act = {4{24'(i + 1)}}; op_wgt = 18'(i + 1);
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if ({mat_en, mat_I_A} !== {1'b0, {4{24'd1}}}) begin errors++; $display("FAIL stall hold: got en=%b A=%h want en=0 A=%h", mat_en, mat_I_A, {4{24'd1}}); end
      end
    end
    op_valid = 1'b0;
    checks++;
    if ({mat_I_A, mat_I_B} !== {{4{24'd7}}, 18'd7}) begin errors++; $display("FAIL stall last operands: got A=%h B=%h", mat_I_A, mat_I_B); end
    for (int n = 0; n < 40 && !res_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({res_valid, res_data} !== {1'b1, 32'h0, 32'hFFFFFFFC}) begin errors++; $display("FAIL stall wait %0d: got rv=%b res=%h want rv=1 res=00000000fffffffc", i, res_valid, res_data); end
      @(negedge clk);
    end
    finish_job({32'h0, 32'hFFFFFFFC}, "stall");
    checks++;
    if ({en_cnt - e0, done_cnt - d0} !== {32'd4, 32'd1}) begin errors++; $display("FAIL stall counts: got en=%0d done=%0d want 4 1", en_cnt - e0, done_cnt - d0); end
  endtask

  task automatic test_zero_tiles;
    int e0 = en_cnt;
    start_job(1'b0, 16'd0);
    checks++;
    if ({res_valid, busy, res_data} !== {2'b11, 64'h0}) begin errors++; $display("FAIL zero first cycle: got rv=%b busy=%b res=%h want 1 1 0", res_valid, busy, res_data); end
    finish_job(64'h0, "zero");
    checks++;
    if (en_cnt !== e0) begin errors++; $display("FAIL zero mat_en count: got %0d want %0d", en_cnt, e0); end
  endtask

  task automatic test_reset_mid;
    int d0 = done_cnt;
    mo_base = en_cnt; mo_val = 32'h12345678; op_valid = 1'b1; op_act = {4{24'h5A5A5A}};
    start_job(1'b1, 16'd5);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, op_ready, mat_en, mat_mode, res_valid, mat_I_A, mat_I_B, res_data} !== '0) begin
      errors++; $display("FAIL mid reset outputs: got busy=%b rdy=%b en=%b mode=%b A=%h res=%h want all 0",
        busy, op_ready, mat_en, mat_mode, mat_I_A, res_data);
    end
    @(negedge clk);
    reset = 1'b0; op_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({done_cnt - d0, 31'(busy)} !== {32'd0, 31'd0}) begin errors++; $display("FAIL mid reset done/busy: got done=%0d busy=%b want 0 0", done_cnt - d0, busy); end
    mo_base = en_cnt; mo_val = 32'h00000007; op_valid = 1'b1;
    start_job(1'b0, 16'd1);
    finish_job({32'h0, 32'h7}, "after reset");
    op_valid = 1'b0;
  endtask

  task automatic test_busy_start_wrap;
    int e0 = en_cnt;
    mo_base = en_cnt; mo_n = 256; mo_val = 32'h007FFFFF; mo_tail = 32'h00000110; op_valid = 1'b1;
    start_job(1'b0, 16'd257);
    repeat (10) @(negedge clk);
    start = 1'b1; mode_cfg = 1'b1; ci_tiles = 16'd1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({mat_mode, busy, op_ready} !== 3'b011) begin errors++; $display("FAIL busy start ignored: got mode=%b busy=%b rdy=%b want 0 1 1", mat_mode, busy, op_ready); end
    finish_job({32'h0, 32'h80000010}, "wrap");
    checks++;
    if (en_cnt - e0 !== 257) begin errors++; $display("FAIL wrap mat_en count: got %0d want 257", en_cnt - e0); end
    op_valid = 1'b0; mo_n = 1000000;
  endtask

  task automatic test_back_to_back;
    int d0 = done_cnt;
    start_job(1'b0, 16'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b done: got %b want 1", done); end
    mo_base = en_cnt; mo_val = 32'h5; op_valid = 1'b1;
    start = 1'b1; mode_cfg = 1'b0; ci_tiles = 16'd1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, op_ready, done} !== 3'b110) begin errors++; $display("FAIL b2b restart: got busy=%b rdy=%b done=%b want 1 1 0", busy, op_ready, done); end
    finish_job({32'h0, 32'h5}, "b2b");
    op_valid = 1'b0;
    checks++;
    if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b done count: got %0d want 2", done_cnt - d0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_mode1;
    test_stall;
    test_zero_tiles;
    test_reset_mid;
    test_busy_start_wrap;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
